// File: rtl/tinymips_prog_loader_pkg.sv
// ----------------------------------------------------------------------------
// tinymips_prog_loader_pkg
//  Shared definitions for the TinyMIPS program loader:
//   - ldr_state_e : 3-bit loader state encoding (LDR_IDLE..LDR_ERR)
//   - OP_*        : TinyMIPS opcode constants, handy for assembling test programs
//  Optional feature macro used by the loader: TINYMIPS_LOADER_CHECKSUM_EN
// ----------------------------------------------------------------------------
package tinymips_prog_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE    = 3'd0,
        LDR_LOAD    = 3'd1,
        LDR_RUN     = 3'd2,
        LDR_DONE    = 3'd3,
        LDR_TIMEOUT = 3'd4,
        LDR_ERR     = 3'd5
    } ldr_state_e;

    // TinyMIPS 16-bit instruction opcodes (top nibble of the word)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_J    = 4'hC;

endpackage

// File: rtl/tinymips_prog_loader_watchdog.sv
// ----------------------------------------------------------------------------
// tinymips_watchdog
//  Saturating run-cycle counter for the program loader.
//  Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (count -> 0)
//   clear_i    synchronous clear (priority over enable)
//   en_i       count one cycle
//   count_o    current count, sticks at all-ones instead of wrapping
//   expired_o  count has reached MAX_CYCLES-1
// ----------------------------------------------------------------------------
module tinymips_watchdog #(
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CYC_W-1:0] count_o,
    output logic             expired_o
);

    localparam logic [CYC_W-1:0] LIMIT = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] CMAX  = '1;

    logic [CYC_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (en_i && (count_q != CMAX))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/tinymips_prog_loader.sv
// ----------------------------------------------------------------------------
// tinymips_prog_loader
//  Boot/run controller between the TinyMIPS core and its single-port RAM.
//  Streams a program into RAM while holding the core in reset, then releases
//  the core, hands it the RAM port, and ends the run on a store to HALT_ADDR
//  or on watchdog expiry.
//  Optional feature: define TINYMIPS_LOADER_CHECKSUM_EN to treat the in_last
//  word as a checksum trailer (sum of preceding words, mod 2^DATA_W).
//  Ports:
//   clk_i, rst_i          clock / synchronous active-high reset
//   start_i               1-cycle pulse, begins a load from IDLE/DONE/TIMEOUT/ERR
//   in_valid_i/in_ready_o program word handshake; in_data_i, in_last_i
//   cpu_rst_o             core reset, low only while running
//   cpu_wrEn_i/addr/dout  core RAM port
//   ram_we_o/addr/din     to the block RAM
//   busy_o                loading or running
//   done_o/timeout_o/error_o  terminal status flags
//   result_o              data of the halt store
//   cycles_o              run cycles elapsed
//   words_loaded_o        program words written to RAM
// ----------------------------------------------------------------------------
module tinymips_prog_loader
    import tinymips_prog_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int HALT_ADDR  = DEPTH - 1,
    parameter int MAX_CYCLES = 4096,
    parameter int CYC_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              cpu_rst_o,
    input  logic              cpu_wrEn_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_dout_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              error_o,
    output logic [DATA_W-1:0] result_o,
    output logic [CYC_W-1:0]  cycles_o,
    output logic [ADDR_W:0]   words_loaded_o
);

`ifdef TINYMIPS_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] HALT_A  = ADDR_W'(HALT_ADDR);

    ldr_state_e          state_q, state_d;
    logic [ADDR_W:0]     ptr_q, ptr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                cpu_rst_q;

    logic                full, accept, trailer, write_word, halt_hit;
    logic                wd_clear, wd_en, wd_expired;

    assign full       = (ptr_q == DEPTH_W);
    assign in_ready_o = (state_q == LDR_LOAD) && !full;
    assign accept     = in_ready_o && in_valid_i;
    // With the checksum build the last word is a trailer: consumed, never stored.
    assign trailer    = CSUM_EN && in_last_i;
    assign write_word = accept && !trailer;
    assign halt_hit   = (state_q == LDR_RUN) && cpu_wrEn_i && (cpu_addr_i == HALT_A);

    tinymips_watchdog #(
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .count_o   (cycles_o),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        words_d  = words_q;
        result_d = result_q;
        sum_d    = sum_q;
        wd_clear = 1'b0;
        wd_en    = 1'b0;

        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_TIMEOUT, LDR_ERR: begin
                if (start_i) begin
                    state_d  = LDR_LOAD;
                    ptr_d    = '0;
                    words_d  = '0;
                    result_d = '0;
                    sum_d    = '0;
                    wd_clear = 1'b1;
                end
            end

            LDR_LOAD: begin
                if (accept) begin
                    if (write_word) begin
                        ptr_d = ptr_q + 1'b1;
                        sum_d = sum_q + in_data_i;
                        if (words_q != '1)
                            words_d = words_q + 1'b1;
                    end
                    if (in_last_i) begin
                        if (CSUM_EN)
                            state_d = (in_data_i == sum_q) ? LDR_RUN : LDR_ERR;
                        else
                            state_d = LDR_RUN;
                    end
                end else if (full && in_valid_i && !in_last_i) begin
                    // Program longer than the RAM: drop the word and stop.
                    state_d = LDR_ERR;
                end
            end

            LDR_RUN: begin
                // A halt store beats a simultaneous watchdog expiry. The counter
                // only advances on cycles that stay in RUN, so it reads
                // MAX_CYCLES-1 after a timeout.
                if (halt_hit) begin
                    result_d = cpu_dout_i;
                    state_d  = LDR_DONE;
                end else if (wd_expired) begin
                    state_d  = LDR_TIMEOUT;
                end else begin
                    wd_en    = 1'b1;
                end
            end

            default: state_d = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= LDR_IDLE;
            ptr_q     <= '0;
            words_q   <= '0;
            result_q  <= '0;
            sum_q     <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            words_q   <= words_d;
            result_q  <= result_d;
            sum_q     <= sum_d;
            // Registered from next state so it is low exactly while state_q==RUN.
            cpu_rst_q <= (state_d != LDR_RUN);
        end
    end

    // RAM port mux: loader in LOAD, core pass-through in RUN, writes blocked otherwise.
    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = cpu_addr_i;
        ram_din_o  = cpu_dout_i;
        case (state_q)
            LDR_LOAD: begin
                ram_we_o   = write_word;
                ram_addr_o = ptr_q[ADDR_W-1:0];
                ram_din_o  = in_data_i;
            end
            LDR_RUN:  ram_we_o = cpu_wrEn_i;
            default:  ram_we_o = 1'b0;
        endcase
    end

    assign cpu_rst_o      = cpu_rst_q;
    assign busy_o         = (state_q == LDR_LOAD) || (state_q == LDR_RUN);
    assign done_o         = (state_q == LDR_DONE);
    assign timeout_o      = (state_q == LDR_TIMEOUT);
    assign error_o        = (state_q == LDR_ERR);
    assign result_o       = result_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_tinymips_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_tinymips_prog_loader
//  Self-checking bench: small loader config (16-word RAM, 50-cycle watchdog),
//  a behavioural RAM, a core stub that issues stores while released, a table of
//  load scenarios, directed corner sequences and randomized load/run trials.
// ----------------------------------------------------------------------------
module tb_tinymips_prog_loader;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int DEP  = 16;
    localparam int HALT = 15;
    localparam int MAXC = 50;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          cpu_wrEn = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_dout = '0;
    logic          in_ready, cpu_rst, ram_we, busy, done, timeout, error;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, result;
    logic [CW-1:0] cycles;
    logic [AW:0]   words_loaded;

    int n_chk  = 0;
    int n_fail = 0;

    tinymips_prog_loader #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .HALT_ADDR(HALT),
        .MAX_CYCLES(MAXC), .CYC_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .cpu_rst_o(cpu_rst), .cpu_wrEn_i(cpu_wrEn), .cpu_addr_i(cpu_addr), .cpu_dout_i(cpu_dout),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_din_o(ram_din),
        .busy_o(busy), .done_o(done), .timeout_o(timeout), .error_o(error),
        .result_o(result), .cycles_o(cycles), .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    // behavioural block RAM plus a log of every write
    int            cyc = 0;
    logic [DW-1:0] ram [DEP];
    int            wr_addr[$];
    int            wr_cyc[$];
    int            run_seen = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            ram[ram_addr] <= ram_din;
            wr_addr.push_back(int'(ram_addr));
            wr_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) if (!cpu_rst) run_seen <= run_seen + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; cpu_wrEn = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
        wr_addr.delete(); wr_cyc.delete();
    endtask

    // Present words one by one; gap_pct inserts idle cycles. Stops early when
    // the loader refuses a word (overflow), after letting it see that word once.
    task automatic stream(input logic [DW-1:0] w[$], input bit use_last, input int gap_pct,
                          output bit rst_at_last);
        int i = 0;
        int guard = 0;
        rst_at_last = 1'b0;
        while (i < w.size() && guard < 400) begin
            guard++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0; in_last = 1'b0;
            end else begin
                in_valid = 1'b1; in_data = w[i];
                in_last  = use_last && (i == w.size() - 1);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (i == w.size() - 1) rst_at_last = cpu_rst;
                i++;
            end else if (in_valid) begin
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Core stub: while released, stores hval to HALT on run cycle halt_at
    // (never if negative); optional random stores elsewhere. Model memory
    // exp_mem/exp_ok tracks what the RAM must end up holding.
    logic [DW-1:0] exp_mem [DEP];
    bit            exp_ok  [DEP];

    task automatic run_core(input int halt_at, input logic [DW-1:0] hval, input bit rnd_wr,
                            output int run_cnt);
        int guard = 0;
        run_cnt = 0;
        while (guard < MAXC + 20) begin
            guard++;
            if (cpu_rst) break;
            cpu_wrEn = 1'b0;
            if (run_cnt == halt_at) begin
                cpu_wrEn = 1'b1; cpu_addr = AW'(HALT); cpu_dout = hval;
                exp_mem[HALT] = hval; exp_ok[HALT] = 1'b1;
            end else if (rnd_wr && $urandom_range(3) == 0) begin
                cpu_wrEn = 1'b1; cpu_addr = AW'($urandom_range(HALT - 1)); cpu_dout = DW'($urandom);
                exp_mem[cpu_addr] = cpu_dout; exp_ok[cpu_addr] = 1'b1;
            end
            run_cnt++;
            tick();
        end
        cpu_wrEn = 1'b0;
    endtask

    function automatic bit mem_ok();
        for (int a = 0; a < DEP; a++)
            if (exp_ok[a] && ram[a] !== exp_mem[a]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_prog(input logic [DW-1:0] w[$], input int n);
        for (int a = 0; a < DEP; a++) exp_ok[a] = 1'b0;
        for (int a = 0; a < n && a < DEP; a++) begin exp_mem[a] = w[a]; exp_ok[a] = 1'b1; end
    endtask

    typedef struct {
        int n;
        bit last;
        int exp_words;
        bit exp_err;
        bit exp_run;
    } vec_t;

    initial begin
        vec_t          tbl[5];
        logic [DW-1:0] w[$];
        bit            rl;
        int            rc;
        int            seen0;

        tbl[0] = '{n: 1,  last: 1'b1, exp_words: 1,  exp_err: 1'b0, exp_run: 1'b1};
        tbl[1] = '{n: 5,  last: 1'b1, exp_words: 5,  exp_err: 1'b0, exp_run: 1'b1};
        tbl[2] = '{n: 16, last: 1'b1, exp_words: 16, exp_err: 1'b0, exp_run: 1'b1};
        tbl[3] = '{n: 16, last: 1'b0, exp_words: 16, exp_err: 1'b0, exp_run: 1'b0};
        tbl[4] = '{n: 17, last: 1'b0, exp_words: 16, exp_err: 1'b1, exp_run: 1'b0};

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("reset_cpu_rst", cpu_rst, 1);
        chk("reset_flags", {busy, done, timeout, error, in_ready, ram_we}, 0);
        chk("reset_counters", {result, cycles, words_loaded}, 0);

`ifndef TINYMIPS_LOADER_CHECKSUM_EN
        // ---- 1: factorial program, valid held high, halt store of 120 ----
        w = '{16'h5101, 16'h5205, 16'h0000, 16'h3211, 16'hB2FE, 16'h92FF};
        set_prog(w, 6);
        pulse_start();
        stream(w, 1'b1, 0, rl);
        chk("t1_rst_at_last_accept", rl, 1);
        chk("t1_cpu_rst_falls", cpu_rst, 0);
        chk("t1_write_count", wr_addr.size(), 6);
        for (int i = 0; i < wr_addr.size() && i < 6; i++) begin
            chk("t1_write_addr", wr_addr[i], i);
            chk("t1_write_consecutive", wr_cyc[i] - wr_cyc[0], i);
        end
        chk("t1_words_loaded", words_loaded, 6);
        run_core(12, 16'd120, 1'b0, rc);
        @(negedge clk);
        chk("t1_done", {done, timeout, error, busy}, 4'b1000);
        chk("t1_result", result, 120);
        chk("t1_cycles", cycles, 12);
        chk("t1_ram", mem_ok(), 1);

        // ---- 2: core never halts, watchdog ----
        pulse_start();
        stream(w, 1'b1, 0, rl);
        run_core(-1, '0, 1'b0, rc);
        chk("t2_run_cycles", rc, MAXC);
        cpu_wrEn = 1'b1; cpu_addr = 4'd3; cpu_dout = 16'hDEAD;
        @(negedge clk);
        chk("t2_timeout", {timeout, done, error}, 3'b100);
        chk("t2_cycles", cycles, MAXC - 1);
        chk("t2_cpu_rst", cpu_rst, 1);
        chk("t2_ram_we_blocked", ram_we, 0);
        tick();
        cpu_wrEn = 1'b0;

        // ---- table of load scenarios (includes 17-word overflow) ----
        foreach (tbl[k]) begin
            do_reset();
            w.delete();
            for (int i = 0; i < tbl[k].n; i++) w.push_back(DW'($urandom));
            set_prog(w, tbl[k].exp_words);
            seen0 = run_seen;
            pulse_start();
            stream(w, tbl[k].last, 0, rl);
            @(negedge clk);
            chk("tbl_words", words_loaded, tbl[k].exp_words);
            chk("tbl_writes", wr_addr.size(), tbl[k].exp_words);
            chk("tbl_error", error, tbl[k].exp_err);
            chk("tbl_cpu_rst", cpu_rst, !tbl[k].exp_run);
            chk("tbl_ram", mem_ok(), 1);
            if (!tbl[k].exp_run) chk("tbl_never_ran", run_seen - seen0, 0);
            tick();
        end

        // ---- 4: reset mid-LOAD, then reload ----
        do_reset();
        w = '{16'h1111, 16'h2222, 16'h3333};
        pulse_start();
        stream(w, 1'b0, 0, rl);
        rc = wr_addr.size();
        rst = 1'b1; tick(); rst = 1'b0;
        in_valid = 1'b1; in_data = 16'h7777;
        @(negedge clk);
        chk("t4_after_reset", {busy, in_ready, ram_we}, 0);
        chk("t4_words_cleared", words_loaded, 0);
        tick();
        in_valid = 1'b0;
        chk("t4_no_extra_writes", wr_addr.size(), rc);
        w = '{16'hAAAA, 16'hBBBB};
        set_prog(w, 2);
        pulse_start();
        stream(w, 1'b1, 0, rl);
        chk("t4_reload_addrs", {wr_addr.size(), (wr_addr.size() == 2) ? wr_addr[0] : -1,
                                (wr_addr.size() == 2) ? wr_addr[1] : -1}, {32'd2, 32'd0, 32'd1});
        chk("t4_words", words_loaded, 2);
        run_core(0, 16'h0001, 1'b0, rc);

        // ---- 5: halt on the watchdog-expiry cycle ----
        pulse_start();
        stream(w, 1'b1, 0, rl);
        run_core(MAXC - 1, 16'hBEEF, 1'b0, rc);
        @(negedge clk);
        chk("t5_done_wins", {done, timeout}, 2'b10);
        chk("t5_result", result, 16'hBEEF);
        chk("t5_cycles", cycles, MAXC - 1);

        // ---- randomized load/run trials against the model ----
        for (int t = 0; t < 20; t++) begin
            int n, h;
            logic [DW-1:0] hv;
            n  = $urandom_range(1, 15);
            h  = $urandom_range(0, 60);
            hv = DW'($urandom);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(DW'($urandom));
            set_prog(w, n);
            pulse_start();
            stream(w, 1'b1, 30, rl);
            chk("rnd_words", words_loaded, n);
            run_core(h, hv, 1'b1, rc);
            @(negedge clk);
            if (h < MAXC) begin
                chk("rnd_done", {done, timeout}, 2'b10);
                chk("rnd_result_cycles", {result, cycles}, {hv, CW'(h)});
            end else begin
                chk("rnd_timeout", {done, timeout}, 2'b01);
                chk("rnd_result_cycles", {result, cycles}, {DW'(0), CW'(MAXC - 1)});
            end
            chk("rnd_ram", mem_ok(), 1);
            tick();
        end
`else
        // ---- 6: checksum trailer ----
        w = '{16'd1, 16'd2, 16'd3, 16'd6};
        pulse_start();
        stream(w, 1'b1, 0, rl);
        chk("t6_run", cpu_rst, 0);
        chk("t6_words", words_loaded, 3);
        chk("t6_writes", wr_addr.size(), 3);
        run_core(2, 16'h0042, 1'b0, rc);
        @(negedge clk);
        chk("t6_done", done, 1);
        w = '{16'd1, 16'd2, 16'd3, 16'd7};
        seen0 = run_seen;
        pulse_start();
        stream(w, 1'b1, 0, rl);
        @(negedge clk);
        chk("t6_bad_error", error, 1);
        chk("t6_bad_no_run", run_seen - seen0, 0);
        w = '{16'd0};
        pulse_start();
        stream(w, 1'b1, 0, rl);
        chk("t6_empty_run", {cpu_rst, words_loaded}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
